// File: rtl/host_interface_fifo.sv
// APB host front end for a block core: input/output word FIFOs plus a load/start/wait/store sequencer.
// Zero-wait-state APB; FIFO overflow/underflow is answered with PSLVERR and a sticky SR flag.
module host_interface_fifo #(
  parameter int BLK_WORDS  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [3:0]              PADDR,
  input  logic [31:0]             PWDATA,
  output logic [31:0]             PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic                    start_core,
  output logic [32*BLK_WORDS-1:0] blk_in,
  input  logic                    ccf_set,
  input  logic [32*BLK_WORDS-1:0] blk_out,
  output logic [1:0]              mode,
  output logic                    disable_core,
  output logic                    irq,
  output logic                    dma_req_wr,
  output logic                    dma_req_rd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(BLK_WORDS);
  localparam int BW = 32 * BLK_WORDS;
  localparam logic [CW-1:0] BLK_C   = CW'(BLK_WORDS);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST    = IW'(BLK_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_STORE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          ld_act;
  logic          cr_en;
  logic [5:0]    cr_cfg;
  logic          ccf, rd_err, wr_err;

  logic [31:0]   in_mem  [FIFO_DEPTH];
  logic [31:0]   out_mem [FIFO_DEPTH];
  logic [AW-1:0] in_wp, in_rp, out_wp, out_rp;
  logic [CW-1:0] in_cnt, out_cnt;

  logic acc, wr_acc, rd_acc, addr_ok;
  logic cr_wr, sr_wr, dinr_wr, doutr_rd, dis;
  logic in_full, out_empty, in_push, out_pop, wr_drop, rd_miss;
  logic ld_go, fsm_pop, fsm_push;
  logic [31:0] in_head, store_word, sr_val;

  assign acc      = PSEL & PENABLE;
  assign wr_acc   = acc & PWRITE;
  assign rd_acc   = acc & ~PWRITE;
  assign addr_ok  = (PADDR < 4'd4);
  assign cr_wr    = wr_acc & (PADDR == 4'd0);
  assign sr_wr    = wr_acc & (PADDR == 4'd1);
  assign dinr_wr  = wr_acc & (PADDR == 4'd2);
  assign doutr_rd = rd_acc & (PADDR == 4'd3);
  assign dis      = cr_wr & ~PWDATA[0];

  assign in_full   = (in_cnt == DEPTH_C);
  assign out_empty = (out_cnt == '0);
  assign in_push   = dinr_wr & cr_en & ~in_full;
  assign wr_drop   = dinr_wr & ~(cr_en & ~in_full);
  assign out_pop   = doutr_rd & ~out_empty;
  assign rd_miss   = doutr_rd & out_empty;

  assign in_head    = in_mem[in_rp];
  assign store_word = blk_out[BW-32-32*int'(idx) +: 32];

  // A block is only pulled once it can be returned whole, so STORE never overflows.
  assign ld_go    = (state == S_LOAD) & ~ld_act & (in_cnt >= BLK_C) & ((DEPTH_C - out_cnt) >= BLK_C);
  assign fsm_pop  = (state == S_LOAD) & (ld_act | ld_go) & ~dis;
  assign fsm_push = (state == S_STORE) & ~dis;

  assign sr_val = {8'd0, 8'(out_cnt), 8'(in_cnt), 5'd0, wr_err, rd_err, ccf};

  assign PREADY       = 1'b1;
  assign PSLVERR      = (acc & ~addr_ok) | wr_drop | rd_miss;
  assign mode         = cr_cfg[1:0];
  assign disable_core = ~cr_en;
  assign irq          = (ccf & cr_cfg[2]) | ((rd_err | wr_err) & cr_cfg[3]);
  assign dma_req_wr   = cr_cfg[4] & cr_en & ((DEPTH_C - in_cnt) >= BLK_C);
  assign dma_req_rd   = cr_cfg[5] & cr_en & (out_cnt >= BLK_C);

  always_comb begin
    PRDATA = '0;
    if (rd_acc) begin
      case (PADDR)
        4'd0:    PRDATA = {25'd0, cr_cfg, cr_en};
        4'd1:    PRDATA = sr_val;
        4'd3:    PRDATA = out_empty ? 32'd0 : out_mem[out_rp];
        default: PRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (in_push)  in_mem[in_wp]   <= PWDATA;
    if (fsm_push) out_mem[out_wp] <= store_word;
  end

  // Disabling the block empties both FIFOs in the same edge that returns the FSM to IDLE.
  always_ff @(posedge PCLK) begin
    if (PRESET || dis) begin
      in_wp   <= '0;
      in_rp   <= '0;
      in_cnt  <= '0;
      out_wp  <= '0;
      out_rp  <= '0;
      out_cnt <= '0;
    end else begin
      if (in_push)  in_wp  <= in_wp + AW'(1);
      if (fsm_pop)  in_rp  <= in_rp + AW'(1);
      if (fsm_push) out_wp <= out_wp + AW'(1);
      if (out_pop)  out_rp <= out_rp + AW'(1);
      in_cnt  <= in_cnt + CW'(in_push) - CW'(fsm_pop);
      out_cnt <= out_cnt + CW'(fsm_push) - CW'(out_pop);
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cr_en  <= 1'b0;
      cr_cfg <= '0;
      ccf    <= 1'b0;
      rd_err <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      if (cr_wr) begin
        cr_en <= PWDATA[0];
        if (state == S_IDLE) cr_cfg <= PWDATA[6:1];
      end
      ccf    <= (ccf    & ~(sr_wr & PWDATA[0])) | ccf_set;
      rd_err <= (rd_err & ~(sr_wr & PWDATA[1])) | rd_miss;
      wr_err <= (wr_err & ~(sr_wr & PWDATA[2])) | wr_drop;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state      <= S_IDLE;
      idx        <= '0;
      ld_act     <= 1'b0;
      start_core <= 1'b0;
      blk_in     <= '0;
    end else if (dis) begin
      state      <= S_IDLE;
      idx        <= '0;
      ld_act     <= 1'b0;
      start_core <= 1'b0;
    end else begin
      start_core <= 1'b0;
      case (state)
        S_IDLE:  if (cr_en) state <= S_LOAD;
        S_LOAD: begin
          if (fsm_pop) begin
            blk_in <= {blk_in[BW-33:0], in_head};
            if (idx == LAST) begin
              idx        <= '0;
              ld_act     <= 1'b0;
              start_core <= 1'b1;
              state      <= S_START;
            end else begin
              idx    <= idx + IW'(1);
              ld_act <= 1'b1;
            end
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (ccf_set) begin
            idx   <= '0;
            state <= S_STORE;
          end
        end
        S_STORE: begin
          if (idx == LAST) begin
            idx   <= '0;
            state <= S_LOAD;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_host_interface_fifo.sv
// Directed bench for host_interface_fifo: register table plus block-flow sequences.
module tb_host_interface_fifo;

  logic         PCLK = 1'b0;
  logic         PRESET = 1'b1;
  logic         PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [3:0]   PADDR = '0;
  logic [31:0]  PWDATA = '0;
  logic [31:0]  PRDATA;
  logic         PREADY, PSLVERR, start_core;
  logic [127:0] blk_in;
  logic         ccf_set = 1'b0;
  logic [127:0] blk_out = '0;
  logic [1:0]   mode;
  logic         disable_core, irq, dma_req_wr, dma_req_rd;

  int total = 0;
  int passed = 0;
  int start_cnt = 0;

  host_interface_fifo #(.BLK_WORDS(4), .FIFO_DEPTH(8)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .start_core(start_core), .blk_in(blk_in), .ccf_set(ccf_set), .blk_out(blk_out),
    .mode(mode), .disable_core(disable_core), .irq(irq),
    .dma_req_wr(dma_req_wr), .dma_req_rd(dma_req_rd)
  );

  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) if (start_core) start_cnt++;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic apb(input logic wr, input logic [3:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    rd = PRDATA;
    err = PSLVERR;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr_chk(input logic [3:0] a, input logic [31:0] d, input logic exp_err, input string nm);
    logic [31:0] rd;
    logic        e;
    apb(1'b1, a, d, rd, e);
    check({nm, "_err"}, 128'(e), 128'(exp_err));
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp_d, input logic exp_err, input string nm);
    logic [31:0] rd;
    logic        e;
    apb(1'b0, a, 32'd0, rd, e);
    check({nm, "_data"}, 128'(rd), 128'(exp_d));
    check({nm, "_err"}, 128'(e), 128'(exp_err));
  endtask

  task automatic do_reset();
    @(negedge PCLK);
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; ccf_set = 1'b0;
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
  endtask

  task automatic pulse_ccf();
    @(negedge PCLK);
    ccf_set = 1'b1;
    @(negedge PCLK);
    ccf_set = 1'b0;
  endtask

  task automatic wait_start(input int target, input string nm);
    int k = 0;
    while (start_cnt < target && k < 60) begin
      @(posedge PCLK);
      #1;
      k++;
    end
    check(nm, 128'(start_cnt), 128'(target));
  endtask

  initial begin
    int base;
    //            wr    addr   data           exp_rdata      err
    tbl[0]  = '{1'b1, 4'd0,  32'h0000_007E, 32'h0,         1'b0};
    tbl[1]  = '{1'b0, 4'd0,  32'h0,         32'h0000_007E, 1'b0};
    tbl[2]  = '{1'b1, 4'd0,  32'hFFFF_FF80, 32'h0,         1'b0};
    tbl[3]  = '{1'b0, 4'd0,  32'h0,         32'h0,         1'b0};
    tbl[4]  = '{1'b0, 4'd4,  32'h0,         32'h0,         1'b1};
    tbl[5]  = '{1'b1, 4'd15, 32'h1,         32'h0,         1'b1};
    tbl[6]  = '{1'b0, 4'd2,  32'h0,         32'h0,         1'b0};
    tbl[7]  = '{1'b1, 4'd2,  32'h55,        32'h0,         1'b1};
    tbl[8]  = '{1'b0, 4'd1,  32'h0,         32'h0000_0004, 1'b0};
    tbl[9]  = '{1'b1, 4'd1,  32'h4,         32'h0,         1'b0};
    tbl[10] = '{1'b0, 4'd1,  32'h0,         32'h0,         1'b0};
    tbl[11] = '{1'b0, 4'd3,  32'h0,         32'h0,         1'b1};
    tbl[12] = '{1'b0, 4'd1,  32'h0,         32'h0000_0002, 1'b0};
    tbl[13] = '{1'b0, 4'd0,  32'h0,         32'h0,         1'b0};

    do_reset();
    #1;
    check("rst_start_core", 128'(start_core), 128'(0));
    check("rst_irq", 128'(irq), 128'(0));
    check("rst_dma_wr", 128'(dma_req_wr), 128'(0));
    check("rst_dma_rd", 128'(dma_req_rd), 128'(0));
    check("rst_pslverr", 128'(PSLVERR), 128'(0));
    check("rst_mode", 128'(mode), 128'(0));
    check("rst_disable", 128'(disable_core), 128'(1));
    check("rst_blk_in", blk_in, 128'(0));
    check("pready", 128'(PREADY), 128'(1));

    for (int i = 0; i < 14; i++) begin
      logic [31:0] rd;
      logic        e;
      apb(tbl[i].wr, tbl[i].addr, tbl[i].data, rd, e);
      if (!tbl[i].wr) check($sformatf("tbl%0d_data", i), 128'(rd), 128'(tbl[i].exp_rdata));
      check($sformatf("tbl%0d_err", i), 128'(e), 128'(tbl[i].exp_err));
    end

    // Single block through the core, then drain DOUTR past empty.
    do_reset();
    base = start_cnt;
    wr_chk(4'd0, 32'h1, 1'b0, "b_cr");
    wr_chk(4'd2, 32'h11, 1'b0, "b_d0");
    wr_chk(4'd2, 32'h22, 1'b0, "b_d1");
    wr_chk(4'd2, 32'h33, 1'b0, "b_d2");
    wr_chk(4'd2, 32'h44, 1'b0, "b_d3");
    wait_start(base + 1, "b_start");
    repeat (4) @(posedge PCLK);
    #1;
    check("b_start_once", 128'(start_cnt), 128'(base + 1));
    check("b_blk_in", blk_in, 128'h00000011_00000022_00000033_00000044);
    blk_out = 128'h0000000A_0000000B_0000000C_0000000D;
    pulse_ccf();
    repeat (6) @(posedge PCLK);
    rd_chk(4'd1, 32'h0004_0001, 1'b0, "b_sr_store");
    rd_chk(4'd3, 32'hA, 1'b0, "b_out0");
    rd_chk(4'd3, 32'hB, 1'b0, "b_out1");
    rd_chk(4'd3, 32'hC, 1'b0, "b_out2");
    rd_chk(4'd3, 32'hD, 1'b0, "b_out3");
    rd_chk(4'd3, 32'h0, 1'b1, "b_out_empty");
    rd_chk(4'd1, 32'h0000_0003, 1'b0, "b_sr_rderr");
    check("b_irq_masked", 128'(irq), 128'(0));

    // Two blocks fill the output FIFO, then the input FIFO overflows.
    do_reset();
    base = start_cnt;
    wr_chk(4'd0, 32'h1, 1'b0, "c_cr");
    for (int i = 0; i < 4; i++) wr_chk(4'd2, 32'h11 * (i + 1), 1'b0, "c_blk1");
    wait_start(base + 1, "c_start1");
    pulse_ccf();
    for (int i = 4; i < 8; i++) wr_chk(4'd2, 32'h11 * (i + 1), 1'b0, "c_blk2");
    wait_start(base + 2, "c_start2");
    check("c_blk_in2", blk_in, 128'h00000055_00000066_00000077_00000088);
    pulse_ccf();
    repeat (6) @(posedge PCLK);
    for (int i = 0; i < 8; i++) wr_chk(4'd2, 32'h100 + i, 1'b0, "c_fill");
    wr_chk(4'd2, 32'h1FF, 1'b1, "c_overflow");
    rd_chk(4'd1, 32'h0008_0805, 1'b0, "c_sr_full");

    // Sticky flags, irq level, and set-over-clear.
    do_reset();
    wr_chk(4'd0, 32'h10, 1'b0, "d_cr_errie");
    rd_chk(4'd3, 32'h0, 1'b1, "d_empty_rd");
    check("d_irq_err", 128'(irq), 128'(1));
    wr_chk(4'd1, 32'h2, 1'b0, "d_clr_rderr");
    check("d_irq_clr", 128'(irq), 128'(0));
    wr_chk(4'd0, 32'h18, 1'b0, "d_cr_ccfie");
    pulse_ccf();
    #1;
    check("d_irq_ccf", 128'(irq), 128'(1));
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 4'd1; PWDATA = 32'h1;
    @(negedge PCLK);
    PENABLE = 1'b1; ccf_set = 1'b1;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; ccf_set = 1'b0;
    rd_chk(4'd1, 32'h1, 1'b0, "d_set_wins");
    wr_chk(4'd1, 32'h1, 1'b0, "d_clr_ccf");
    rd_chk(4'd1, 32'h0, 1'b0, "d_sr_clear");
    check("d_irq_off", 128'(irq), 128'(0));

    // Disable during WAIT with queued input words.
    do_reset();
    base = start_cnt;
    wr_chk(4'd0, 32'h1, 1'b0, "e_cr");
    for (int i = 0; i < 4; i++) wr_chk(4'd2, 32'h11 * (i + 1), 1'b0, "e_blk");
    wait_start(base + 1, "e_start");
    for (int i = 0; i < 3; i++) wr_chk(4'd2, 32'hE0 + i, 1'b0, "e_queue");
    rd_chk(4'd1, 32'h0000_0300, 1'b0, "e_sr_queued");
    wr_chk(4'd0, 32'h5, 1'b0, "e_cr_busy");
    check("e_mode_locked", 128'(mode), 128'(0));
    check("e_still_en", 128'(disable_core), 128'(0));
    wr_chk(4'd0, 32'h0, 1'b0, "e_disable");
    rd_chk(4'd1, 32'h0, 1'b0, "e_sr_flushed");
    wr_chk(4'd0, 32'h4, 1'b0, "e_cr_idle");
    check("e_mode_set", 128'(mode), 128'(2));
    check("e_disable_core", 128'(disable_core), 128'(1));
    check("e_blk_in_kept", blk_in, 128'h00000011_00000022_00000033_00000044);

    // DMA request levels.
    do_reset();
    base = start_cnt;
    wr_chk(4'd0, 32'h61, 1'b0, "f_cr");
    check("f_dma_wr_empty", 128'(dma_req_wr), 128'(1));
    check("f_dma_rd_empty", 128'(dma_req_rd), 128'(0));
    for (int i = 1; i <= 4; i++) wr_chk(4'd2, i, 1'b0, "f_blk1");
    wait_start(base + 1, "f_start1");
    for (int i = 5; i <= 9; i++) wr_chk(4'd2, i, 1'b0, "f_five");
    check("f_dma_wr_low", 128'(dma_req_wr), 128'(0));
    rd_chk(4'd1, 32'h0000_0500, 1'b0, "f_sr_five");
    blk_out = 128'h000000F1_000000F2_000000F3_000000F4;
    pulse_ccf();
    wait_start(base + 2, "f_start2");
    check("f_dma_wr_back", 128'(dma_req_wr), 128'(1));
    check("f_dma_rd_high", 128'(dma_req_rd), 128'(1));
    rd_chk(4'd1, 32'h0004_0101, 1'b0, "f_sr_after");
    check("f_blk_in2", blk_in, 128'h00000005_00000006_00000007_00000008);

    // Reset in the middle of a load abandons the block.
    do_reset();
    base = start_cnt;
    wr_chk(4'd0, 32'h1, 1'b0, "g_cr");
    for (int i = 1; i <= 4; i++) wr_chk(4'd2, 32'h70 + i, 1'b0, "g_blk");
    @(negedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b1;
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    repeat (20) @(posedge PCLK);
    #1;
    check("g_no_start", 128'(start_cnt), 128'(base));
    check("g_blk_in_zero", blk_in, 128'(0));
    check("g_disabled", 128'(disable_core), 128'(1));
    rd_chk(4'd1, 32'h0, 1'b0, "g_sr_zero");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
